// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared constants, M-op encodings and FSM states for muldiv.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [2:0] C_F3_MUL    = 3'b000;
    localparam logic [2:0] C_F3_MULH   = 3'b001;
    localparam logic [2:0] C_F3_MULHSU = 3'b010;
    localparam logic [2:0] C_F3_MULHU  = 3'b011;
    localparam logic [2:0] C_F3_DIV    = 3'b100;
    localparam logic [2:0] C_F3_DIVU   = 3'b101;
    localparam logic [2:0] C_F3_REM    = 3'b110;
    localparam logic [2:0] C_F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Purpose  : One combinational shift-add (mode 0) or restoring-divide
//             (mode 1) iteration on magnitudes.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             mode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0] shreg_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] shreg_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    // Multiply keeps {acc, shreg} as a 2*WIDTH product shifted right each step.
    assign w_sum   = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, opnd_i} : '0);
    assign w_trial = {acc_i, shreg_i[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, opnd_i});
    // Remainder stays below the divisor, so the difference fits in WIDTH bits.
    assign w_sub   = w_trial[WIDTH-1:0] - opnd_i;

    always_comb begin
        acc_o   = acc_i;
        shreg_o = shreg_i;
        if (mode_i) begin
            acc_o   = w_ge ? w_sub : w_trial[WIDTH-1:0];
            shreg_o = {shreg_i[WIDTH-2:0], w_ge};
        end else begin
            acc_o   = w_sum[WIDTH:1];
            shreg_o = {w_sum[0], shreg_i[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative RV32M multiply/divide unit with pipeline stall/kill.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             kill,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic             sgn_a_q, sgn_a_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             w_sgn_a, w_sgn_b;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic             w_div_zero, w_ovf;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH-1:0] w_step_acc, w_step_shreg;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0] w_quo, w_rem, w_fix_res;

    assign w_sgn_a = op_a[WIDTH-1] & ((funct3 == C_F3_DIV) | (funct3 == C_F3_REM) |
                                      (funct3 == C_F3_MULH) | (funct3 == C_F3_MULHSU));
    assign w_sgn_b = op_b[WIDTH-1] & ((funct3 == C_F3_DIV) | (funct3 == C_F3_REM) |
                                      (funct3 == C_F3_MULH));
    assign w_mag_a = w_sgn_a ? -op_a : op_a;
    assign w_mag_b = w_sgn_b ? -op_b : op_b;

    assign w_div_zero = funct3[2] & (op_b == '0);
    assign w_ovf      = ((funct3 == C_F3_DIV) | (funct3 == C_F3_REM)) &
                        (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (op_b == '1);
    // REM/REMU have funct3[1] set: divide-by-zero returns the dividend, overflow returns 0.
    assign w_special_res = w_div_zero ? (funct3[1] ? op_a : '1)
                                      : (funct3[1] ? '0   : op_a);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i  (f3_q[2]),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .shreg_i (shreg_q),
        .acc_o   (w_step_acc),
        .shreg_o (w_step_shreg)
    );

    assign w_prod   = {acc_q, shreg_q};
    assign w_prod_s = neg_q ? -w_prod : w_prod;
    assign w_quo    = neg_q ? -shreg_q : shreg_q;
    assign w_rem    = sgn_a_q ? -acc_q : acc_q;

    always_comb begin
        w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
        case (f3_q)
            C_F3_MUL:             w_fix_res = w_prod_s[WIDTH-1:0];
            C_F3_DIV, C_F3_DIVU:  w_fix_res = w_quo;
            C_F3_REM, C_F3_REMU:  w_fix_res = w_rem;
            default:              w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        acc_d    = acc_q;
        shreg_d  = shreg_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        sgn_a_d  = sgn_a_q;
        result_d = result_q;
        stall    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    stall   = 1'b1;
                    f3_d    = funct3;
                    neg_d   = w_sgn_a ^ w_sgn_b;
                    sgn_a_d = w_sgn_a;
                    if (w_div_zero || w_ovf) begin
                        result_d = w_special_res;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d   = '0;
                        shreg_d = w_mag_a;
                        opnd_d  = w_mag_b;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                stall = 1'b1;
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = w_step_acc;
                    shreg_d = w_step_shreg;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == C_LAST) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                stall = 1'b1;
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = w_fix_res;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                // Any start seen here belongs to the retiring instruction.
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            sgn_a_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            acc_q    <= acc_d;
            shreg_q  <= shreg_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            sgn_a_q  <= sgn_a_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Directed self-checking bench for muldiv_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .kill    (kill),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit hold,
                          input string tag);
        int n;
        bit seen;
        bit stall_ok;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        kill   = 1'b0;
        #1;
        check({tag, " stall@T"}, 32'(stall), 32'd1);
        @(posedge clock);
        #1;
        op_a = 32'hDEADBEEF;
        op_b = 32'h0BADF00D;
        n = 0;
        seen = 1'b0;
        stall_ok = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clock);
            n++;
            if (done) seen = 1'b1;
            else if (!stall) stall_ok = 1'b0;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " stall in DONE"}, 32'(stall), 32'd0);
        check({tag, " stall held"}, 32'(stall_ok), 32'd1);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        reset_n = 1'b0;
        start   = 1'b0;
        kill    = 1'b0;
        funct3  = 3'b000;
        op_a    = '0;
        op_b    = '0;
        repeat (3) @(negedge clock);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0, "MUL 7*-3");
        @(negedge clock);
        check("done one-cycle pulse", 32'(done), 32'd0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0, "MULH");
        @(negedge clock);
        run_op(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0, "MULHU");
        @(negedge clock);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34, 1'b0, "MULHSU");
        @(negedge clock);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b0, "DIV -7/2");
        @(negedge clock);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0, "REM -7/2");
        @(negedge clock);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0, "DIVU 100/7");
        @(negedge clock);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b0, "REMU 100/7");
        @(negedge clock);
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0, "DIVU 5/0");
        @(negedge clock);
        run_op(3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b0, "REM 5/0");
        @(negedge clock);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0, "DIV ovf");
        @(negedge clock);

        // Kill in the tenth CALC cycle.
        funct3 = 3'b100;
        op_a   = 32'd100;
        op_b   = 32'd7;
        start  = 1'b1;
        repeat (10) @(negedge clock);
        check("kill pre stall", 32'(stall), 32'd1);
        check("kill pre busy", 32'(busy), 32'd1);
        kill  = 1'b1;
        start = 1'b0;
        @(negedge clock);
        kill = 1'b0;
        check("kill stall", 32'(stall), 32'd0);
        check("kill busy", 32'(busy), 32'd0);
        check("kill done", 32'(done), 32'd0);
        check("kill result kept", result, 32'h80000000);
        run_op(3'b100, 32'd100, 32'd7, 32'd14, 34, 1'b0, "DIV after kill");
        @(negedge clock);

        // start together with kill in IDLE must not be accepted.
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd3;
        start  = 1'b1;
        kill   = 1'b1;
        #1;
        check("start+kill stall", 32'(stall), 32'd0);
        @(negedge clock);
        check("start+kill busy", 32'(busy), 32'd0);
        check("start+kill done", 32'(done), 32'd0);
        start = 1'b0;
        kill  = 1'b0;
        @(negedge clock);

        // Back-to-back with start held through DONE.
        run_op(3'b000, 32'd6, 32'd7, 32'd42, 34, 1'b1, "B2B op1");
        @(negedge clock);
        check("B2B idle stall", 32'(stall), 32'd1);
        check("B2B idle busy", 32'(busy), 32'd0);
        check("B2B idle done", 32'(done), 32'd0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0, "B2B op2");
        @(negedge clock);

        // Asynchronous reset in the middle of CALC.
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        start  = 1'b1;
        repeat (5) @(negedge clock);
        check("pre-reset busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset result", result, 32'd0);
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check("no done after reset", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
